// File: rtl/risc16_pkg.sv
// risc16_pkg: constants and types shared by the RiSC-16 instruction-memory
// loader. Holds the memory geometry, the frame start marker, the loader state
// encoding and a helper that turns a frame COUNT byte into a word count.
package risc16_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int INSTR_W     = 16;
  localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } loader_state_e;

  // A COUNT of zero stands for a full memory image.
  function automatic int unsigned frame_words(input logic [7:0] count,
                                              input int unsigned depth);
    if (count == 8'h00) begin
      return depth;
    end else begin
      return {24'h00_0000, count};
    end
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: the loader's two buses bundled together.
//   rx_data/rx_valid/rx_ready : byte stream from the UART receive side
//   csb0/web0/addr0/din0      : instruction-memory SRAM write port (strobes active low)
// master: the byte source / memory model side. slave: the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              csb0;
  logic              web0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] din0;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, csb0, web0, addr0, din0
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, csb0, web0, addr0, din0
  );
endinterface

// File: rtl/imem_loader_byte_gap_timer.sv
// byte_gap_timer: measures idle cycles between bytes of a frame.
//   clk0, reset : clock, asynchronous active-low reset
//   load_i      : a byte was accepted this cycle, restart the measurement
//   clear_i     : not inside a frame, hold the counter at zero
//   en_i        : inside a frame, count this cycle
//   expired_o   : this is idle cycle number GAP_MAX (no byte arrives in it)
module byte_gap_timer #(
  parameter int GAP_MAX = 65535
) (
  input  logic clk0,
  input  logic reset,
  input  logic load_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  // The counter only has to reach GAP_MAX-1; the GAP_MAX-th idle cycle is
  // flagged combinationally so the FSM leaves on exactly that edge.
  localparam int CW = (GAP_MAX > 2) ? $clog2(GAP_MAX) : 1;
  localparam logic [CW-1:0] LAST  = CW'(GAP_MAX - 1);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] cnt_q;

  // Idle-cycle counter: restart on a byte, saturate at LAST.
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i || clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + ONE_C;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired_o = en_i & ~load_i & ~clear_i & (cnt_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the RiSC-16 instruction memory.
// Frame = SYNC, COUNT, 2*N data bytes (hi first), CHK = XOR(COUNT, data).
// Each received word is written to the SRAM with a single-cycle csb0/web0
// strobe; the core is held until a frame with a matching checksum lands.
//   clk0, reset   : clock, asynchronous active-low reset
//   bus (slave)   : rx byte stream in, SRAM write port out
//   core_hold     : 1 holds the core; drops only in DONE
//   load_done     : one-cycle pulse entering DONE
//   load_err      : level set entering ERR, cleared by the next accepted SYNC
//   words_loaded  : words written by the current/last frame
module imem_loader #(
  parameter int         ADDR_W    = risc16_pkg::IMEM_ADDR_W,
  parameter int         DATA_W    = risc16_pkg::INSTR_W,
  parameter logic [7:0] SYNC_BYTE = risc16_pkg::SYNC_BYTE,
  parameter int         GAP_MAX   = 65535
) (
  input  logic            clk0,
  input  logic            reset,
  imem_loader_if.slave    bus,
  output logic            core_hold,
  output logic            load_done,
  output logic            load_err,
  output logic [ADDR_W:0] words_loaded
);
  import risc16_pkg::*;

  localparam int unsigned     DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE_W = (ADDR_W + 1)'(1);

  loader_state_e     state_q;
  logic [7:0]        hi_q;
  logic [7:0]        chk_q;
  logic [ADDR_W:0]   nwords_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              csb_q;
  logic              web_q;
  logic              rdy_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  logic              byte_acc;
  logic              is_sync;
  logic              in_frame;
  logic              at_rest;
  logic              gap_expired;
  logic [ADDR_W:0]   words_d;
  int unsigned       count_words;

  // rx_ready is gated by reset so it reads 0 while reset is held.
  assign bus.rx_ready = reset & rdy_q;
  assign byte_acc     = bus.rx_valid & bus.rx_ready;
  assign is_sync      = (bus.rx_data == SYNC_BYTE);
  assign in_frame     = (state_q == COUNT) || (state_q == HI) ||
                        (state_q == LO)    || (state_q == CHK);
  assign at_rest      = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
  assign words_d      = words_q + ONE_W;
  assign count_words  = frame_words(bus.rx_data, DEPTH);

  byte_gap_timer #(
    .GAP_MAX (GAP_MAX)
  ) u_gap (
    .clk0      (clk0),
    .reset     (reset),
    .load_i    (byte_acc),
    .clear_i   (at_rest),
    .en_i      (in_frame),
    .expired_o (gap_expired)
  );

  // Loader FSM with its datapath and registered outputs.
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hi_q     <= 8'h00;
      chk_q    <= 8'h00;
      nwords_q <= '0;
      words_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      rdy_q    <= 1'b1;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // Strobes and the done pulse last one cycle unless re-armed below.
      csb_q  <= 1'b1;
      web_q  <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          // Any non-SYNC byte is swallowed here.
          if (byte_acc && is_sync) begin
            state_q <= COUNT;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            words_q <= '0;
          end
        end
        COUNT: begin
          if (gap_expired) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (byte_acc) begin
            chk_q    <= bus.rx_data;
            nwords_q <= (ADDR_W + 1)'(count_words);
            addr_q   <= '0;
            if (count_words > DEPTH) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= HI;
            end
          end
        end
        HI: begin
          if (gap_expired) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (byte_acc) begin
            hi_q    <= bus.rx_data;
            chk_q   <= chk_q ^ bus.rx_data;
            state_q <= LO;
          end
        end
        LO: begin
          // The strobe is set up here so it is driven during the WRITE cycle.
          if (gap_expired) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (byte_acc) begin
            chk_q   <= chk_q ^ bus.rx_data;
            din_q   <= DATA_W'({hi_q, bus.rx_data});
            addr_q  <= words_q[ADDR_W-1:0];
            csb_q   <= 1'b0;
            web_q   <= 1'b0;
            rdy_q   <= 1'b0;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          words_q <= words_d;
          rdy_q   <= 1'b1;
          if (words_d == nwords_q) begin
            state_q <= CHK;
          end else begin
            state_q <= HI;
          end
        end
        CHK: begin
          if (gap_expired) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (byte_acc) begin
            if (bus.rx_data == chk_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.csb0     = csb_q;
  assign bus.web0     = web_q;
  assign bus.addr0    = addr_q;
  assign bus.din0     = din_q;
  assign core_hold    = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule
